// File: rtl/pc_flag_unit.sv
// Program counter and condition-flag unit: latches ALU N/V/Z flags, evaluates
// branch conditions against them, and sequences the PC through branches and halt.
module pc_flag_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        alu_valid,
    input  logic [2:0]  alu_opcode,
    input  logic [2:0]  alu_flags,
    input  logic        branch,
    input  logic        branch_reg,
    input  logic [2:0]  cond,
    input  logic [8:0]  offset,
    input  logic [15:0] reg_target,
    input  logic        halt,
    output logic [15:0] pc,
    output logic [2:0]  flags,
    output logic        taken,
    output logic        halted
);

    localparam int unsigned PC_W   = 16;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_RED    = 3'b010,
        OP_XOR    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_OV = 3'b110,
        CC_AL = 3'b111
    } cond_t;

    state_t          state;
    logic            cond_true;
    logic            any_branch;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] offset_ext;
    logic [PC_W-1:0] pc_rel;
    logic            f_n;
    logic            f_v;
    logic            f_z;

    assign f_n = flags[FLAG_N];
    assign f_v = flags[FLAG_V];
    assign f_z = flags[FLAG_Z];

    // Condition codes look only at the latched flags, never same-cycle ALU output
    always_comb begin
        cond_true = 1'b0;
        case (cond_t'(cond))
            CC_NE:   cond_true = ~f_z;
            CC_EQ:   cond_true = f_z;
            CC_GT:   cond_true = ~f_z & ~f_n;
            CC_LT:   cond_true = f_n;
            CC_GE:   cond_true = f_z | (~f_z & ~f_n);
            CC_LE:   cond_true = f_n | f_z;
            CC_OV:   cond_true = f_v;
            CC_AL:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign any_branch = branch | branch_reg;
    assign taken      = any_branch & cond_true & (state == ST_RUN) & ~halt;

    // Word offset: sign-extend 9 bits and scale by two bytes
    assign offset_ext = {{(PC_W - 10){offset[8]}}, offset, 1'b0};
    assign pc_seq     = pc + PC_W'(2);
    assign pc_rel     = pc_seq + offset_ext;

    // State, PC, flags and halted; halt > branch > alu priority, stall freezes all
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            pc     <= RESET_PC;
            flags  <= 3'b000;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        if (halt) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end else if (any_branch) begin
                            if (taken) begin
                                pc <= branch_reg ? reg_target : pc_rel;
                            end else begin
                                pc <= pc_seq;
                            end
                        end else begin
                            pc <= pc_seq;
                            if (alu_valid) begin
                                case (alu_op_t'(alu_opcode))
                                    OP_ADD, OP_SUB: flags <= alu_flags;
                                    OP_XOR, OP_SLL, OP_SRA, OP_ROR:
                                        flags[FLAG_Z] <= alu_flags[FLAG_Z];
                                    default: flags <= flags;
                                endcase
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: doc/pc_flag_unit.md
# pc_flag_unit

Sequential consumer of the ALU's condition flags. Latches the N/V/Z flags the ALU produces on each flag-setting instruction, evaluates 3-bit branch condition codes against the latched flags, and owns the 16-bit program counter, including sequential increment, PC-relative and register branches, and halt. Sits between the ALU flag output and instruction fetch in the single-cycle core.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC, flags and state this cycle
- alu_valid  in  1  current instruction is an ALU op; flags may update
- alu_opcode  in  3  ALU opcode: 000 ADD, 001 SUB, 010 RED, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB
- alu_flags  in  3  ALU flags: [2]=N, [1]=V, [0]=Z
- branch  in  1  current instruction is B (PC-relative)
- branch_reg  in  1  current instruction is BR (register target)
- cond  in  3  branch condition code
- offset  in  9  signed word offset for B
- reg_target  in  16  target address for BR
- halt  in  1  current instruction is HLT
- pc  out  16  current PC (registered)
- flags  out  3  latched {N,V,Z} (registered)
- taken  out  1  combinational: the branch in the current cycle is taken
- halted  out  1  registered: the core is halted

## Operation
- States: RUN and HALTED.
  - In RUN, the unit processes one instruction per cycle unless stall is high.
  - HALTED is left only by rst.
- Priority in RUN when several strobes are high: halt > branch/branch_reg > alu_valid.
  - A lower-priority strobe asserted with a higher one is ignored; flags are not updated.
  - If branch and branch_reg are both high, branch_reg wins.
- Flag update applies only when alu_valid=1 in RUN with no stall and no higher-priority strobe:
  - ADD, SUB: N, V and Z all load from alu_flags.
  - XOR, SLL, SRA, ROR: only Z loads; N and V hold.
  - RED, PADDSB: no flag changes.
- Condition evaluation uses the latched flags, never the same-cycle alu_flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always
- taken = (branch or branch_reg) and cond true and state RUN and not halt. It is combinational and does not depend on stall.
- Next PC in RUN without stall:
  - halt: pc holds; halted goes to 1.
  - taken with branch_reg: reg_target, used unmodified.
  - taken with branch: pc + 2 + (sign-extend(offset) << 1).
  - Otherwise: pc + 2.
- Arithmetic is 16-bit modulo 2^16. Wrap-around is silent, e.g. 16'hFFFE + 2 = 16'h0000.
- HALTED: pc, flags and halted hold; all inputs are ignored; taken=0.

## Timing
- Reset, synchronous, on the clk edge with rst=1: pc=RESET_PC, flags=3'b000, halted=0, state RUN.
  - rst overrides stall and every other input.
  - rst mid-branch or mid-halt discards the pending update.
- pc, flags and halted update on the rising clk edge following the instruction cycle. Latency is 1 cycle.
- A flag-setting op in cycle n is visible to a branch in cycle n+1. A branch in the same cycle n sees the pre-update flags.
- stall=1: no register changes; taken is still driven from current inputs.
- HLT in cycle n: halted=1 and pc unchanged from cycle n+1 on. pc keeps the HLT address.

## Test plan
- Reset with RESET_PC=16'h0000, 3 idle cycles -> pc 0000, 0002, 0004, 0006; flags=000; halted=0.
- alu_valid, ADD, alu_flags=3'b001; next cycle branch, cond=001, offset=9'h1FE (-2), pc=16'h0010 -> taken=1, next pc=16'h000E. Same branch with cond=000 -> taken=0, pc=16'h0012.
- Flags latched 3'b110, then alu_valid XOR with alu_flags=3'b001 -> flags=3'b111. Then PADDSB with alu_flags=3'b000 -> flags still 3'b111.
- Same cycle: alu_valid SUB with alu_flags=3'b001, branch cond=001, latched Z=0 -> taken=0, flags unchanged (branch priority).
- branch_reg cond=111, reg_target=16'hABCD -> pc=16'hABCD. Then pc=16'hFFFE, idle -> pc=16'h0000.
- halt at pc=16'h0040 -> halted=1 and pc=0040 held for 5 cycles despite branch strobes. Then rst=1 for one cycle -> pc=RESET_PC, halted=0. stall=1 with a taken branch -> pc unchanged.
